sensor_cmd_arbiter: RTL and testbench
=====================================

// Module: sensor_cmd_arbiter
// PURPOSE
//  Generalised sensor-to-command arbiter for the car controller; replaces the fixed 2-input tilt/sound decoder.
//  Samples N_CH asynchronous sensor triggers on a prescaled tick and requires each trigger to persist before accepting it.
//  Selects one channel by fixed priority and issues a one-hot-free command code to the motor controller over a valid/ready handshake.
//  Sits between the sensor front-ends (MPU, sound, ...) and the drive/motion FSM.
// PARAMETERS
//  N_CH     2   number of sensor trigger channels (1..7)
//  DIV_W    16  prescaler width; tick period = 2^DIV_W clk cycles (762 Hz at 50 MHz)
//  CONFIRM  2   consecutive high ticks required to accept a trigger (>=1)
//  CODE_W   3   command code width; must satisfy 2^CODE_W > N_CH (elaboration error otherwise)
// PORTS
//  clk        in   1       system clock, 50 MHz
//  reset      in   1       synchronous, active-high reset
//  sens_in    in   N_CH    raw asynchronous sensor triggers, active-high, bit 0 = highest priority
//  cmd_ready  in   1       downstream accepts command when high with cmd_valid
//  cmd_valid  out  1       command pending
//  cmd_code   out  CODE_W  command code: channel index + 1; 0 = no command
//  busy       out  1       high whenever FSM is not IDLE
// BEHAVIOUR
//  Reset: prescaler=0, sync flops=0, FSM=IDLE, cnt=0, cmd_valid=0, cmd_code=0, busy=0.
//   Reset asserted mid-operation drops any pending command; no partial output survives.
//  Prescaler: DIV_W-bit free-running up-counter; tick = 1-cycle pulse when counter==all-ones; wraps to 0.
//  Input sync: 2 flops per channel; FSM sees sens_s = sens_in delayed 2 clk.
//  FSM (advances only on tick, except ISSUE which is evaluated every clk):
//   IDLE  : tick & |sens_s -> sel=lowest set index, cnt=1; go ISSUE if CONFIRM==1 else ARM.
//   ARM   : tick & sens_s[sel] -> cnt++; cnt reaches CONFIRM -> ISSUE.
//           tick & !sens_s[sel] -> IDLE, cnt=0. No preemption by a higher-priority channel.
//   ISSUE : cmd_valid=1, cmd_code=sel+1 (registered, asserted first clk after entry).
//           cmd_valid & cmd_ready -> COOL next clk; cmd_valid stays high until accepted.
//   COOL  : tick & !sens_s[sel] -> IDLE; a held trigger never reissues (release required).
//  cmd_ready while cmd_valid=0 is ignored. Tick coinciding with handshake: handshake wins, tick ignored that clk.
//  All channels high at once -> channel 0 selected; others ignored until IDLE.
//  cnt width = clog2(CONFIRM+1); saturates, never wraps.
// CONFIGURATION
//  CMD_LATCH_EN defined: cmd_code holds last issued code after handshake until next ISSUE (legacy latched-mode behaviour).
//  CMD_LATCH_EN undefined: cmd_code = sel+1 only while cmd_valid=1, else 0.
//  cmd_valid, handshake and FSM timing identical in both builds.
// STRUCTURE
//  Package sensor_cmd_pkg: FSM state enum (IDLE, ARM, ISSUE, COOL), CODE_NONE=0 constant, clog2 function.
//  Sub-module tick_prescaler (param DIV_W; ports clk, reset, tick) instantiated once.
//  Sync flops, priority encoder, FSM and output regs live in this module.
// TESTING  (DIV_W=2 -> tick every 4 clk, N_CH=2, CONFIRM=2, CODE_W=3)
//  1 Reset: hold reset 3 clk with sens_in=2'b11 -> cmd_valid=0, cmd_code=0, busy=0 throughout and 1 clk after release.
//  2 Accept: sens_in=2'b01 held, cmd_ready=1 -> cmd_valid high for 1 clk, cmd_code=1, after 2 ticks; no reissue while held.
//  3 Glitch: sens_in[1] high for 1 tick only -> busy pulses, FSM returns IDLE, cmd_valid never asserts.
//  4 Priority: sens_in=2'b11 -> cmd_code=1; sens_in=2'b10 alone after release -> cmd_code=2.
//  5 Backpressure: cmd_ready=0 for 20 clk during ISSUE -> cmd_valid/cmd_code stable; accepted on first cmd_ready=1 clk.
//  6 Mode: after test 2, cmd_code=1 persists with CMD_LATCH_EN, returns to 0 without; reset mid-ISSUE clears both.

Source files
------------

// File: rtl/sensor_cmd_pkg.sv
// Shared types for the sensor command arbiter.
// FSM state enum, empty-command code and a clog2 helper.
package sensor_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    ISSUE = 2'd2,
    COOL  = 2'd3
  } state_e;

  localparam int CODE_NONE = 0;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sensor_cmd_arbiter_prescaler.sv
// Free-running prescaler; one-clk tick when the counter is all-ones.
// Ports: clk, reset (sync, active-high), tick (1-clk pulse).
module tick_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  logic [DIV_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_q + 1'b1;
  end

  assign tick = &cnt_q;

endmodule

// File: rtl/sensor_cmd_arbiter.sv
// Sensor-trigger arbiter: sync, confirm on ticks, issue command code.
// Ports: clk, reset, sens_in, cmd_ready / cmd_valid, cmd_code, busy.
// Build option CMD_LATCH_EN: cmd_code keeps last issued code when idle.
module sensor_cmd_arbiter
  import sensor_cmd_pkg::*;
#(
  parameter int N_CH    = 2,
  parameter int DIV_W   = 16,
  parameter int CONFIRM = 2,
  parameter int CODE_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   sens_in,
  input  logic              cmd_ready,
  output logic              cmd_valid,
  output logic [CODE_W-1:0] cmd_code,
  output logic              busy
);

  localparam int CNT_W = clog2(CONFIRM + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CONFIRM);

  if ((1 << CODE_W) <= N_CH) begin : g_code_w_chk
    $error("CODE_W too narrow for N_CH");
  end
  if (N_CH < 1 || N_CH > 7) begin : g_n_ch_chk
    $error("N_CH out of range 1..7");
  end
  if (CONFIRM < 1) begin : g_confirm_chk
    $error("CONFIRM must be >= 1");
  end

  logic tick;

  tick_prescaler #(
    .DIV_W (DIV_W)
  ) u_presc (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  logic [N_CH-1:0] s1_q;
  logic [N_CH-1:0] s2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= sens_in;
      s2_q <= s1_q;
    end
  end

  state_e            state_q, state_d;
  logic [CODE_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CODE_W-1:0] pick;
  logic [N_CH-1:0]   sel_sh;
  logic              sel_hit;

  // Lowest set index wins: scan from the top so bit 0 lands last.
  always_comb begin
    pick = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (s2_q[i]) pick = CODE_W'(i);
    end
  end

  assign sel_sh  = s2_q >> sel_q;
  assign sel_hit = sel_sh[0];

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (tick && (|s2_q)) begin
          sel_d   = pick;
          cnt_d   = CNT_W'(1);
          state_d = (CONFIRM == 1) ? ISSUE : ARM;
        end
      end
      ARM: begin
        if (tick) begin
          if (sel_hit) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            if (cnt_d == CNT_MAX) state_d = ISSUE;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      // Evaluated every clk; a coincident tick is irrelevant here.
      ISSUE: begin
        if (valid_q && cmd_ready) state_d = COOL;
      end
      COOL: begin
        if (tick && !sel_hit) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d = (state_d == ISSUE);
`ifdef CMD_LATCH_EN
    code_d = code_q;
`else
    code_d = CODE_W'(CODE_NONE);
`endif
    if (state_d == ISSUE) code_d = sel_d + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      code_q  <= CODE_W'(CODE_NONE);
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      code_q  <= code_d;
    end
  end

  assign cmd_valid = valid_q;
  assign cmd_code  = code_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sensor_cmd_arbiter.sv
// Scoreboard bench for sensor_cmd_arbiter (DIV_W=2, N_CH=2, CONFIRM=2).
// Honours CMD_LATCH_EN the same way the design does.
module tb_sensor_cmd_arbiter;

  localparam int N_CH    = 2;
  localparam int DIV_W   = 2;
  localparam int CONFIRM = 2;
  localparam int CODE_W  = 3;
  localparam int PERIOD  = 1 << DIV_W;
`ifdef CMD_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [N_CH-1:0]   sens_in;
  logic              cmd_ready;
  logic              cmd_valid;
  logic [CODE_W-1:0] cmd_code;
  logic              busy;

  always #5 clk = ~clk;

  sensor_cmd_arbiter #(
    .N_CH    (N_CH),
    .DIV_W   (DIV_W),
    .CONFIRM (CONFIRM),
    .CODE_W  (CODE_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sens_in   (sens_in),
    .cmd_ready (cmd_ready),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .busy      (busy)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic int lowest(input logic [N_CH-1:0] v);
    int r;
    r = -1;
    for (int i = N_CH - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  // Reference model: tracks the locked channel, its run of high
  // ticks, a pending command and the wait-for-release condition.
  int              m_n = 0;
  logic [N_CH-1:0] m_h1 = '0;
  logic [N_CH-1:0] m_h2 = '0;
  int              m_hold = -1;
  int              m_run = 0;
  bit              m_pend = 0;
  bit              m_rel = 0;
  int              m_last = 0;
  bit              started = 0;
  int              exp_q[$];

  always @(posedge clk) begin : model
    int n_hold, n_run, n_last;
    bit n_pend, n_rel, tk;
    logic [N_CH-1:0] s;
    if (reset) begin
      m_n <= 0;
      m_h1 <= '0;
      m_h2 <= '0;
      m_hold <= -1;
      m_run <= 0;
      m_pend <= 0;
      m_rel <= 0;
      m_last <= 0;
      started <= 1;
      exp_q.delete();
    end else begin
      tk = (m_n % PERIOD) == PERIOD - 1;
      s = m_h2;
      n_hold = m_hold;
      n_run = m_run;
      n_pend = m_pend;
      n_rel = m_rel;
      n_last = m_last;
      if (m_pend) begin
        if (cmd_ready) begin
          n_pend = 0;
          n_rel = 1;
        end
      end else if (tk) begin
        if (m_hold < 0) begin
          if (s != 0) begin
            n_hold = lowest(s);
            n_run = 1;
          end
        end else if (m_rel) begin
          if (!s[m_hold]) begin
            n_hold = -1;
            n_rel = 0;
          end
        end else if (s[m_hold]) begin
          n_run = m_run + 1;
        end else begin
          n_hold = -1;
        end
        if (n_hold >= 0 && !n_rel && n_run >= CONFIRM) begin
          n_pend = 1;
          n_last = n_hold + 1;
          exp_q.push_back(n_hold + 1);
        end
      end
      m_hold <= n_hold;
      m_run <= n_run;
      m_pend <= n_pend;
      m_rel <= n_rel;
      m_last <= n_last;
      m_n <= m_n + 1;
      m_h1 <= sens_in;
      m_h2 <= m_h1;
    end
  end

  int hs_cnt = 0;
  int last_hs_code = 0;
  bit busy_seen = 0;
  bit valid_seen = 0;

  always @(negedge clk) begin : monitor
    int ex_code;
    if (started) begin
      ex_code = m_pend ? m_last : (LATCH ? m_last : 0);
      chk("valid", int'(cmd_valid), int'(m_pend));
      chk("busy", int'(busy), int'(m_hold >= 0));
      chk("code", int'(cmd_code), ex_code);
      if (busy) busy_seen = 1;
      if (cmd_valid) valid_seen = 1;
      if (cmd_valid && cmd_ready && !reset) begin
        hs_cnt++;
        last_hs_code = int'(cmd_code);
        if (exp_q.size() == 0) begin
          chk("hs_expected", 1, 0);
        end else begin
          chk("hs_code", int'(cmd_code), exp_q.pop_front());
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_hs(input int code, input int budget, input string nm);
    int h0;
    bit got;
    h0 = hs_cnt;
    got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      cyc(1);
      if (hs_cnt != h0) got = 1;
    end
    chk(nm, int'(got), 1);
    if (got) begin
      chk({nm, "_code"}, last_hs_code, code);
      chk({nm, "_drop"}, int'(cmd_valid), 0);
    end
  endtask

  task automatic wait_valid(input int budget, input string nm);
    bit got;
    got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      cyc(1);
      if (cmd_valid) got = 1;
    end
    chk(nm, int'(got), 1);
  endtask

  initial begin
    int h0;
    int c0;
    reset = 1'b1;
    sens_in = 2'b11;
    cmd_ready = 1'b1;

    // Reset held with triggers asserted
    cyc(3);
    chk("t1_valid", int'(cmd_valid), 0);
    chk("t1_code", int'(cmd_code), 0);
    chk("t1_busy", int'(busy), 0);
    reset = 1'b0;
    sens_in = 2'b00;
    cyc(1);
    chk("t1_rel_valid", int'(cmd_valid), 0);
    chk("t1_rel_busy", int'(busy), 0);

    // Accept on channel 0, no reissue while held
    sens_in = 2'b01;
    wait_hs(1, 40, "t2_hs");
    h0 = hs_cnt;
    cyc(30);
    chk("t2_noreissue", hs_cnt, h0);
    chk("t6_code_hold", int'(cmd_code), LATCH ? 1 : 0);
    sens_in = 2'b00;
    cyc(12);
    chk("t2_idle", int'(busy), 0);

    // One-tick glitch on channel 1
    busy_seen = 0;
    valid_seen = 0;
    h0 = hs_cnt;
    sens_in = 2'b10;
    cyc(PERIOD);
    sens_in = 2'b00;
    cyc(16);
    chk("t3_busy_pulse", int'(busy_seen), 1);
    chk("t3_no_valid", int'(valid_seen), 0);
    chk("t3_no_hs", hs_cnt, h0);
    chk("t3_idle", int'(busy), 0);

    // Priority then lower channel alone
    sens_in = 2'b11;
    wait_hs(1, 40, "t4_hi");
    sens_in = 2'b00;
    cyc(12);
    sens_in = 2'b10;
    wait_hs(2, 40, "t4_lo");
    sens_in = 2'b00;
    cyc(12);

    // Backpressure
    cmd_ready = 1'b0;
    sens_in = 2'b01;
    wait_valid(40, "t5_valid");
    c0 = int'(cmd_code);
    chk("t5_code", c0, 1);
    h0 = hs_cnt;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      chk("t5_hold_valid", int'(cmd_valid), 1);
      chk("t5_hold_code", int'(cmd_code), c0);
    end
    cmd_ready = 1'b1;
    cyc(1);
    chk("t5_accept", hs_cnt, h0 + 1);
    chk("t5_drop", int'(cmd_valid), 0);
    sens_in = 2'b00;
    cyc(12);

    // Reset during a pending command
    cmd_ready = 1'b0;
    sens_in = 2'b01;
    wait_valid(40, "t6_valid");
    reset = 1'b1;
    cyc(1);
    chk("t6_rst_valid", int'(cmd_valid), 0);
    chk("t6_rst_code", int'(cmd_code), 0);
    chk("t6_rst_busy", int'(busy), 0);
    reset = 1'b0;
    sens_in = 2'b00;
    cmd_ready = 1'b1;
    cyc(4);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) sens_in = N_CH'($urandom_range(0, 3));
      cmd_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 199) == 0);
      cyc(1);
    end
    reset = 1'b0;
    sens_in = 2'b00;
    cmd_ready = 1'b1;
    cyc(20);
    chk("end_queue_empty", exp_q.size(), 0);
    chk("end_idle", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
